// File: rtl/lfsr_gen_if.sv
// Random-word handshake between lfsr_gen and its consumer.
// Master drives the word and valid; slave returns ready.
interface lfsr_gen_if #(
  parameter int OUT_BITS = 4
);
  logic [OUT_BITS-1:0] rnd_word;
  logic                rnd_valid;
  logic                rnd_ready;

  modport master (
    output rnd_word,
    output rnd_valid,
    input  rnd_ready
  );

  modport slave (
    input  rnd_word,
    input  rnd_valid,
    output rnd_ready
  );
endinterface

// File: rtl/lfsr_gen.sv
// Galois LFSR random-word source with seed loading and handshake.
// Define LFSR_GEN_WRAP_EN to build the seed register and wrap pulse.
module lfsr_gen #(
  parameter int              WIDTH    = 16,
  parameter int              OUT_BITS = 4,
  parameter logic [WIDTH-1:0] TAPS    = 16'hB400,
  parameter logic [WIDTH-1:0] SEED    = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  lfsr_gen_if.master       rnd,
  output logic [WIDTH-1:0] lfsr_state,
  output logic             seed_err,
  output logic             wrap
);

  localparam int CW = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(OUT_BITS - 1);

  typedef enum logic {
    FILL,
    HOLD
  } state_e;

  state_e              st_q, st_d;
  logic [WIDTH-1:0]    lfsr_q, lfsr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OUT_BITS-1:0] word_q, word_d;
  logic [OUT_BITS-1:0] rword_q, rword_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                step;
  logic [WIDTH-1:0]    seed_eff;
  logic [WIDTH-1:0]    stepped;
  logic [OUT_BITS:0]   shift_in;
  logic [OUT_BITS-1:0] shifted;

  always_comb begin
    stepped  = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    shift_in = {lfsr_q[0], word_q};
    shifted  = shift_in[OUT_BITS:1];
    seed_eff = (seed_in == '0) ? SEED : seed_in;
  end

  always_comb begin
    st_d    = st_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    rword_d = rword_q;
    valid_d = valid_q;
    err_d   = err_q;
    step    = 1'b0;
    if (seed_load) begin
      lfsr_d  = seed_eff;
      err_d   = (seed_in == '0);
      cnt_d   = '0;
      word_d  = '0;
      valid_d = 1'b0;
      st_d    = FILL;
    end else begin
      unique case (st_q)
        FILL: begin
          if (enable) begin
            step   = 1'b1;
            lfsr_d = stepped;
            word_d = shifted;
            if (cnt_q == LAST) begin
              rword_d = shifted;
              valid_d = 1'b1;
              cnt_d   = '0;
              st_d    = HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (valid_q && rnd.rnd_ready) begin
            valid_d = 1'b0;
            st_d    = FILL;
          end
        end
        default: st_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q    <= FILL;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      word_q  <= '0;
      rword_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      rword_q <= rword_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

`ifdef LFSR_GEN_WRAP_EN
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             wrap_q, wrap_d;

  // Wrap compares against the seed the current sequence started from.
  always_comb begin
    seed_d = seed_load ? seed_eff : seed_q;
    wrap_d = step && (lfsr_d == seed_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seed_q <= SEED;
      wrap_q <= 1'b0;
    end else begin
      seed_q <= seed_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif

  assign rnd.rnd_word  = rword_q;
  assign rnd.rnd_valid = valid_q;
  assign lfsr_state    = lfsr_q;
  assign seed_err      = err_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default 16-bit build plus a 5-bit
// full-period instance exercising wrap and state coverage.
module tb_lfsr_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [15:0] lfsr_state;
  logic        seed_err;
  logic        wrap;

  logic        rst2;
  logic        en2 = 1'b1;
  logic        ld2 = 1'b0;
  logic [4:0]  sin2 = '0;
  logic [4:0]  st2;
  logic        err2;
  logic        wrap2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  lfsr_gen_if #(.OUT_BITS(4)) rif ();
  lfsr_gen_if #(.OUT_BITS(1)) rif2 ();

  assign rif2.rnd_ready = 1'b1;

  lfsr_gen dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .rnd        (rif.master),
    .lfsr_state (lfsr_state),
    .seed_err   (seed_err),
    .wrap       (wrap)
  );

  lfsr_gen #(
    .WIDTH    (5),
    .OUT_BITS (1),
    .TAPS     (5'h14),
    .SEED     (5'h1F)
  ) dut2 (
    .clock      (clock),
    .reset      (rst2),
    .enable     (en2),
    .seed_load  (ld2),
    .seed_in    (sin2),
    .rnd        (rif2.master),
    .lfsr_state (st2),
    .seed_err   (err2),
    .wrap       (wrap2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic       seen [32];
  logic [4:0] prev;
  int         steps;
  int         nvis;
  int         nwrap;
  int         exp_wraps;
  logic       exp_w;

  initial begin
    reset     = 1'b0;
    rst2      = 1'b0;
    enable    = 1'b1;
    seed_load = 1'b0;
    seed_in   = '0;
    rif.rnd_ready = 1'b0;
    cyc(2);
    chk("rst_state", 32'(lfsr_state), 32'hFFFF);
    chk("rst_valid", 32'(rif.rnd_valid), 32'h0);
    chk("rst_word", 32'(rif.rnd_word), 32'h0);
    chk("rst_err", 32'(seed_err), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);

    reset = 1'b1;
    cyc(3);
    chk("fill3_valid", 32'(rif.rnd_valid), 32'h0);
    chk("fill3_state", 32'(lfsr_state), 32'hDCFF);
    cyc(1);
    chk("w1_valid", 32'(rif.rnd_valid), 32'h1);
    chk("w1_word", 32'(rif.rnd_word), 32'hF);
    chk("w1_state", 32'(lfsr_state), 32'hDA7F);
    cyc(3);
    chk("hold_state", 32'(lfsr_state), 32'hDA7F);
    chk("hold_valid", 32'(rif.rnd_valid), 32'h1);
    chk("hold_word", 32'(rif.rnd_word), 32'hF);

    rif.rnd_ready = 1'b1;
    cyc(1);
    chk("acc_valid", 32'(rif.rnd_valid), 32'h0);
    chk("acc_nostep", 32'(lfsr_state), 32'hDA7F);
    rif.rnd_ready = 1'b0;
    cyc(2);
    chk("f2_state", 32'(lfsr_state), 32'hD89F);
    enable = 1'b0;
    cyc(1);
    chk("en0_state", 32'(lfsr_state), 32'hD89F);
    chk("en0_valid", 32'(rif.rnd_valid), 32'h0);
    enable = 1'b1;
    cyc(1);
    chk("stretch_valid", 32'(rif.rnd_valid), 32'h0);
    chk("stretch_state", 32'(lfsr_state), 32'hD84F);
    cyc(1);
    chk("w2_valid", 32'(rif.rnd_valid), 32'h1);
    chk("w2_word", 32'(rif.rnd_word), 32'hF);
    chk("w2_state", 32'(lfsr_state), 32'hD827);

    seed_load = 1'b1;
    seed_in   = 16'h0000;
    cyc(1);
    chk("z_state", 32'(lfsr_state), 32'hFFFF);
    chk("z_err", 32'(seed_err), 32'h1);
    chk("z_valid", 32'(rif.rnd_valid), 32'h0);
    seed_in = 16'h0001;
    cyc(1);
    chk("s1_state", 32'(lfsr_state), 32'h0001);
    chk("s1_err", 32'(seed_err), 32'h0);
    seed_load = 1'b0;
    cyc(3);
    chk("s1_fill_valid", 32'(rif.rnd_valid), 32'h0);
    cyc(1);
    chk("s1_valid", 32'(rif.rnd_valid), 32'h1);
    chk("s1_word", 32'(rif.rnd_word), 32'h1);
    chk("s1_state4", 32'(lfsr_state), 32'h1680);

    rif.rnd_ready = 1'b1;
    seed_load = 1'b1;
    seed_in   = 16'h00F8;
    cyc(1);
    chk("drop_valid", 32'(rif.rnd_valid), 32'h0);
    chk("drop_state", 32'(lfsr_state), 32'h00F8);
    seed_load = 1'b0;
    rif.rnd_ready = 1'b0;
    cyc(3);
    chk("drop_fill_valid", 32'(rif.rnd_valid), 32'h0);
    cyc(1);
    chk("f8_valid", 32'(rif.rnd_valid), 32'h1);
    chk("f8_word", 32'(rif.rnd_word), 32'h8);
    chk("f8_state", 32'(lfsr_state), 32'hB40F);

    rif.rnd_ready = 1'b1;
    cyc(1);
    rif.rnd_ready = 1'b0;
    seed_load = 1'b1;
    seed_in   = 16'h0000;
    cyc(1);
    seed_load = 1'b0;
    chk("z2_err", 32'(seed_err), 32'h1);
    cyc(2);
    chk("mid_state", 32'(lfsr_state), 32'hD1FF);
    chk("mid_word", 32'(rif.rnd_word), 32'h8);
    #2 reset = 1'b0;
    #1;
    chk("async_state", 32'(lfsr_state), 32'hFFFF);
    chk("async_word", 32'(rif.rnd_word), 32'h0);
    chk("async_valid", 32'(rif.rnd_valid), 32'h0);
    chk("async_err", 32'(seed_err), 32'h0);

`ifdef LFSR_GEN_WRAP_EN
    exp_wraps = 2;
`else
    exp_wraps = 0;
`endif
    foreach (seen[i]) seen[i] = 1'b0;
    steps = 0;
    nvis  = 0;
    nwrap = 0;
    @(negedge clock);
    chk("d2_rst_state", 32'(st2), 32'h1F);
    prev = st2;
    rst2 = 1'b1;
    for (int c = 0; c < 124; c++) begin
      @(negedge clock);
      exp_w = 1'b0;
      if (st2 != prev) begin
        steps++;
        if (steps <= 31) begin
          if (st2 != 5'd0 && !seen[st2]) nvis++;
          seen[st2] = 1'b1;
        end
        exp_w = (exp_wraps != 0) && (st2 == 5'h1F);
      end
      if (wrap2) nwrap++;
      chk("d2_wrap", 32'(wrap2), 32'(exp_w));
      prev = st2;
    end
    chk("d2_steps", 32'(steps), 32'd62);
    chk("d2_visited", 32'(nvis), 32'd31);
    chk("d2_nwrap", 32'(nwrap), 32'(exp_wraps));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
